// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the asynchronous-SRAM controller:
//   - state_t      : controller FSM states (IDLE, SETUP, ACCESS, DONE)
//   - DEF_ADDR_W   : default SRAM word-address width
//   - DEF_DATA_W   : default data width (multiple of 8)
//   - DEF_WAIT_CYC : default access-phase length in cycles (1..15)
//   - WCNT_W       : width of the access-phase wait counter
//   - wait_load()  : value loaded into the wait counter on entry to ACCESS
// -----------------------------------------------------------------------------
package sram_ctrl_pkg;

    localparam int DEF_ADDR_W   = 15;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_WAIT_CYC = 1;
    localparam int WCNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // The counter leaves ACCESS when it reaches zero, so an access phase of
    // N cycles loads N-1. Out-of-range values are clamped into 1..15 so the
    // 4-bit counter can never wrap.
    function automatic logic [WCNT_W-1:0] wait_load(input int cyc);
        int c;
        if (cyc < 1) begin
            c = 1;
        end else if (cyc > 15) begin
            c = 15;
        end else begin
            c = cyc;
        end
        return WCNT_W'(c - 1);
    endfunction

endpackage

// File: rtl/sram_dq_buf.sv
// -----------------------------------------------------------------------------
// sram_dq_buf
// Bidirectional pad buffer for the SRAM data bus.
//   oe   : in    drive enable (1 = drive dout onto pad, 0 = hi-Z)
//   dout : in    data to drive when oe is 1
//   din  : out   value currently seen on the pad
//   pad  : inout SRAM data pins
// -----------------------------------------------------------------------------
module sram_dq_buf #(
    parameter int W = 16
) (
    input  logic         oe,
    input  logic [W-1:0] dout,
    output logic [W-1:0] din,
    inout  wire  [W-1:0] pad
);

    assign pad = oe ? dout : {W{1'bz}};
    assign din = pad;

endmodule

// File: rtl/sram_ctrl_param.sv
// -----------------------------------------------------------------------------
// sram_ctrl_param
// Single-request controller for an asynchronous SRAM. A host request is
// latched in IDLE and played out as SETUP -> ACCESS (WAIT_CYC cycles) -> DONE,
// with a one-cycle rsp_valid pulse in DONE. DONE also serves as write hold /
// bus-turnaround time before the next access.
//
// Parameters:
//   ADDR_W   SRAM word-address width
//   DATA_W   data width, multiple of 8
//   WAIT_CYC access-phase length in cycles, 1..15
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   host request handshake (ready only in IDLE)
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   req_be                byte enables, active-high
//   rsp_valid             one-cycle completion pulse (reads and writes)
//   rsp_rdata             read data, held until the next read completes
//   sram_addr, sram_dq    SRAM address and bidirectional data bus
//   sram_ce_n/oe_n/we_n   SRAM strobes, active-low
//   sram_be_n             SRAM byte-lane enables, active-low
//
// Build option:
//   SRAM_CTRL_BE_EN  when defined, req_be is latched and driven (inverted) on
//                    sram_be_n so disabled lanes are left untouched by writes.
//                    When undefined, req_be is ignored and every access is
//                    full-width.
// -----------------------------------------------------------------------------
module sram_ctrl_param
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,

    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,

    output logic [ADDR_W-1:0]   sram_addr,
    inout  wire  [DATA_W-1:0]   sram_dq,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic [DATA_W/8-1:0] sram_be_n
);

    localparam int                BE_W      = DATA_W / 8;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYC);

    state_t              state_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                ready_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_n_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic                drive_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [DATA_W-1:0]   dq_in;
    logic [BE_W-1:0]     be_n_load;

    // Active-low lane enables loaded at acceptance.
`ifdef SRAM_CTRL_BE_EN
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be_lane
        assign be_n_load[gi] = ~req_be[gi];
    end
`else
    // Full-width accesses: byte enables from the host are not used.
    logic unused_be;
    assign unused_be = ^req_be;
    assign be_n_load = '0;
`endif

    // Controller FSM. All SRAM strobes are registered so they change only on
    // clock edges and never glitch; each is set up one state ahead of where it
    // must be asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_n_q      <= '1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_n_q  <= be_n_load;
                        ce_n_q  <= 1'b0;
                        // Reads enable the SRAM output from SETUP; writes keep
                        // OE high and drive the bus from SETUP instead, so the
                        // two never coincide.
                        oe_n_q  <= req_we;
                        drive_q <= req_we;
                        ready_q <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    wcnt_q  <= WAIT_LOAD;
                    we_n_q  <= ~we_q;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (wcnt_q == '0) begin
                        // Last access cycle: capture read data and release
                        // the access strobes; CE, address and write data stay
                        // put through DONE for hold time.
                        if (!we_q) begin
                            rdata_q <= dq_in;
                        end
                        we_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end
                end
                DONE: begin
                    ce_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    be_n_q  <= '1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sram_dq_buf #(
        .W (DATA_W)
    ) u_dq_buf (
        .oe   (drive_q),
        .dout (wdata_q),
        .din  (dq_in),
        .pad  (sram_dq)
    );

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_be_n = be_n_q;

endmodule

// File: doc/sram_ctrl_param.md
SRAM_CTRL_PARAM -- requirements
Module: sram_ctrl_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, SRAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 16, data width in bits; SHALL be a multiple of 8.
REQ-003 SHALL have parameter WAIT_CYC, default 1, access-phase length in cycles; legal range 1..15.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  host request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_we  input  1  request type: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_W  request word address.
REQ-010 SHALL have port req_wdata  input  DATA_W  write data.
REQ-011 SHALL have port req_be  input  DATA_W/8  byte enables, active-high.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data; valid while rsp_valid is 1, held until the next read completes.
REQ-014 SHALL have SRAM ports sram_addr out ADDR_W, sram_dq inout DATA_W, sram_ce_n/sram_oe_n/sram_we_n out 1, sram_be_n out DATA_W/8; all strobes active-low.

Function
REQ-015 FSM states SHALL be IDLE, SETUP, ACCESS and DONE, with sequence IDLE->SETUP->ACCESS (WAIT_CYC cycles)->DONE->IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 On acceptance, req_we, req_addr, req_wdata and req_be SHALL be registered; host inputs SHALL be ignored until the next IDLE.
REQ-018 sram_addr and sram_be_n SHALL be driven from the registered values; they SHALL be stable from SETUP through DONE.
REQ-019 sram_ce_n SHALL be 0 in SETUP, ACCESS and DONE, and 1 in IDLE.
REQ-020 Read: sram_oe_n SHALL be 0 in SETUP and ACCESS; sram_dq SHALL be hi-Z throughout.
REQ-021 Read: rsp_rdata SHALL load sram_dq on the edge ending the last ACCESS cycle.
REQ-022 Write: sram_dq SHALL be driven from SETUP through DONE (hold time); sram_we_n SHALL be 0 only in ACCESS; sram_oe_n SHALL stay 1.
REQ-023 rsp_valid SHALL be 1 for exactly the DONE cycle; accept-to-rsp_valid latency SHALL be WAIT_CYC+2 cycles.
REQ-024 Minimum request spacing SHALL be WAIT_CYC+3 cycles; DONE provides bus turnaround between consecutive accesses.
REQ-025 A wait counter of 4 bits SHALL load WAIT_CYC-1 on entry to ACCESS and leave ACCESS on reaching 0.
REQ-026 sram_dq SHALL never be driven while sram_oe_n is 0.

Reset
REQ-027 While rst_n is 0, state SHALL be IDLE and req_ready SHALL be 1 after release.
REQ-028 While rst_n is 0, rsp_valid SHALL be 0, rsp_rdata SHALL be 0, and all strobes and sram_be_n SHALL be all-ones.
REQ-029 While rst_n is 0, sram_dq SHALL be hi-Z and sram_addr SHALL be 0.
REQ-030 Reset mid-operation SHALL abort the access immediately and produce no rsp_valid.

Configuration
REQ-031 With macro SRAM_CTRL_BE_EN defined, sram_be_n SHALL equal ~registered req_be, and disabled byte lanes SHALL be unchanged by writes.
REQ-032 Without SRAM_CTRL_BE_EN, req_be SHALL be ignored and sram_be_n SHALL be all-zero during SETUP..DONE, so every access is full-width.

Structure
REQ-033 Package sram_ctrl_pkg SHALL hold the state_t enum and default ADDR_W/DATA_W/WAIT_CYC constants.
REQ-034 Tristate drive of sram_dq SHALL be in sub-module sram_dq_buf (ports: oe, dout, din, pad).

Verification (model SRAM, DATA_W=16)
REQ-035 WAIT_CYC=2: write 0xBEEF to 0x1234, then read 0x1234 -> rsp_rdata=0xBEEF; rsp_valid 4 cycles after accept; sram_we_n low exactly 2 cycles.
REQ-036 BE_EN defined: write 0x00AA, be=2'b01, over 0xBEEF, then read -> 0xBEAA; without BE_EN the same read -> 0x00AA.
REQ-037 req_valid held high, WAIT_CYC=1, alternating read/write -> accept every 4 cycles; read/write overlap on sram_dq is never flagged.
REQ-038 rst_n low during the 2nd ACCESS cycle of a write (WAIT_CYC=3) -> strobes 1 and dq hi-Z in the same cycle; no rsp_valid; req_ready=1 after release.
REQ-039 Requests with changing addr/data presented while busy -> ignored; the in-flight access uses the latched values.
